// File: rtl/dcpu_sequencer.sv
// Instruction sequencer for the dcpu datapath: fetches 2-byte instructions, decodes them and
// drives regfile/ALU selects, PC strobes and the memory handshake, with timeout and halt detection.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_FETCH0 | read instruction byte0 from mem[PC], PC += 1 on ack
// S_FETCH1 | read instruction byte1 from mem[PC], PC += 1 on ack
// S_DECODE | selects settle from IR, no strobes or requests
// S_EXEC   | execute ALU / LOAD / STORE / JUMP, then back to S_FETCH0
// S_HALT   | halted (HALT instruction or memory timeout), left only by reset
module dcpu_sequencer #(
  parameter logic [2:0]  PC_ADDR_SEL = 3'd7,
  parameter logic [2:0]  OP_PASS     = 3'd0,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_dat,
  input  logic [2:0] i_flags,
  input  logic       i_mem_ack,
  output logic       o_mem_rd,
  output logic       o_mem_wr,
  output logic       o_dat_sel,
  output logic       o_load,
  output logic [3:0] o_load_reg_sel,
  output logic [3:0] o_alu_l_sel,
  output logic [3:0] o_alu_r_sel,
  output logic [2:0] o_addr_sel,
  output logic [2:0] o_op,
  output logic       o_pc_inc,
  output logic       o_pc_load,
  output logic       o_halt,
  output logic       o_fault
);

  typedef enum logic [2:0] {S_FETCH0, S_FETCH1, S_DECODE, S_EXEC, S_HALT} state_t;

  localparam logic [1:0] CLS_ALU   = 2'b00;
  localparam logic [1:0] CLS_LOAD  = 2'b01;
  localparam logic [1:0] CLS_STORE = 2'b10;
  localparam logic [1:0] CLS_JUMP  = 2'b11;
  localparam logic [2:0] COND_HALT = 3'b111;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       run_q;
  logic [7:0] ir0_q, ir1_q;
  logic [7:0] wait_q, wait_d;
  logic       fault_q, fault_d;
  logic       ir0_en, ir1_en;
  logic       cond_true;

  logic [1:0] cls;
  logic [2:0] op, cond;
  logic [3:0] dst, src;

  assign cls  = ir0_q[7:6];
  assign op   = ir0_q[5:3];
  assign cond = ir0_q[2:0];
  assign dst  = ir1_q[7:4];
  assign src  = ir1_q[3:0];

  // i_flags = {N, C, Z}
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = i_flags[0];
      3'b010:  cond_true = !i_flags[0];
      3'b011:  cond_true = i_flags[1];
      3'b100:  cond_true = !i_flags[1];
      3'b101:  cond_true = i_flags[2];
      3'b110:  cond_true = !i_flags[2];
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    ir0_en         = 1'b0;
    ir1_en         = 1'b0;
    wait_d         = 8'd0;
    fault_d        = fault_q;
    o_mem_rd       = 1'b0;
    o_mem_wr       = 1'b0;
    o_dat_sel      = 1'b0;
    o_load         = 1'b0;
    o_load_reg_sel = 4'd0;
    o_alu_l_sel    = 4'd0;
    o_alu_r_sel    = 4'd0;
    o_addr_sel     = 3'd0;
    o_op           = 3'd0;
    o_pc_inc       = 1'b0;
    o_pc_load      = 1'b0;
    o_halt         = 1'b0;

    // run_q keeps every output low during the cycle in which reset is released
    if (run_q) begin
      case (state_q)
        S_FETCH0, S_FETCH1: begin
          o_addr_sel = PC_ADDR_SEL;
          o_mem_rd   = 1'b1;
          o_dat_sel  = 1'b1;
          if (i_mem_ack) begin
            o_pc_inc = 1'b1;
            if (state_q == S_FETCH0) begin
              ir0_en  = 1'b1;
              state_d = S_FETCH1;
            end else begin
              ir1_en  = 1'b1;
              state_d = S_DECODE;
            end
          end
        end
        S_DECODE, S_EXEC: begin
          o_alu_l_sel    = dst;
          o_alu_r_sel    = src;
          o_load_reg_sel = dst;
          o_addr_sel     = src[2:0];
          o_op           = (cls == CLS_STORE) ? OP_PASS : op;
          o_dat_sel      = (cls == CLS_LOAD);
          if (state_q == S_DECODE) begin
            state_d = S_EXEC;
          end else begin
            case (cls)
              CLS_ALU: begin
                o_load  = 1'b1;
                state_d = S_FETCH0;
              end
              CLS_LOAD: begin
                o_mem_rd = 1'b1;
                if (i_mem_ack) begin
                  o_load  = 1'b1;
                  state_d = S_FETCH0;
                end
              end
              CLS_STORE: begin
                o_mem_wr = 1'b1;
                if (i_mem_ack) state_d = S_FETCH0;
              end
              CLS_JUMP: begin
                if (cond == COND_HALT) begin
                  state_d = S_HALT;
                end else begin
                  o_pc_load = cond_true;
                  state_d   = S_FETCH0;
                end
              end
              default: state_d = S_FETCH0;
            endcase
          end
        end
        S_HALT:  o_halt = 1'b1;
        default: state_d = S_FETCH0;
      endcase

      // an ack arriving in the last allowed cycle still completes the transfer
      if ((o_mem_rd || o_mem_wr) && !i_mem_ack) begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
    end
  end

  assign o_fault = fault_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_FETCH0;
      run_q   <= 1'b0;
      ir0_q   <= 8'd0;
      ir1_q   <= 8'd0;
      wait_q  <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      wait_q  <= wait_d;
      fault_q <= fault_d;
      if (ir0_en) ir0_q <= i_dat;
      if (ir1_en) ir1_q <= i_dat;
    end
  end

endmodule

// File: tb/tb_dcpu_sequencer.sv
// Scoreboard bench for dcpu_sequencer: a memory responder streams instruction bytes, directed
// programs push expected strobe events, and a monitor pops and compares them as they occur.
module tb_dcpu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_dat;
  logic [2:0] i_flags;
  logic       i_mem_ack;
  logic       o_mem_rd, o_mem_wr, o_dat_sel, o_load;
  logic [3:0] o_load_reg_sel, o_alu_l_sel, o_alu_r_sel;
  logic [2:0] o_addr_sel, o_op;
  logic       o_pc_inc, o_pc_load, o_halt, o_fault;

  always #5 clk = ~clk;

  dcpu_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_dat(i_dat), .i_flags(i_flags), .i_mem_ack(i_mem_ack),
    .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr), .o_dat_sel(o_dat_sel), .o_load(o_load),
    .o_load_reg_sel(o_load_reg_sel), .o_alu_l_sel(o_alu_l_sel), .o_alu_r_sel(o_alu_r_sel),
    .o_addr_sel(o_addr_sel), .o_op(o_op), .o_pc_inc(o_pc_inc), .o_pc_load(o_pc_load),
    .o_halt(o_halt), .o_fault(o_fault)
  );

  typedef enum int {K_ALU, K_MEMLD, K_STORE, K_PCL, K_HALT} kind_t;
  typedef struct {
    kind_t       kind;
    logic [23:0] sig;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  byte unsigned mem_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          ack_delay = 0;
  bit          stall = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [23:0] observe(kind_t k);
    case (k)
      K_ALU:   return {7'b0, o_load, o_dat_sel, o_load_reg_sel, o_alu_l_sel, o_alu_r_sel, o_op};
      K_MEMLD: return {13'b0, o_load, i_mem_ack, o_dat_sel, o_load_reg_sel, o_addr_sel, 1'b0};
      K_STORE: return {11'b0, o_mem_wr, i_mem_ack, o_dat_sel, o_alu_l_sel, o_op, o_addr_sel};
      K_PCL:   return {19'b0, o_pc_load, o_load, o_addr_sel};
      default: return {20'b0, o_halt, o_fault, o_mem_rd, o_mem_wr};
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got=%0h required=%0h (cycle %0d)", name, got, req, cyc);
    end
  endtask

  task automatic push(kind_t k, logic [23:0] sig, int c);
    exp_t e;
    e.kind = k;
    e.sig  = sig;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic push_alu(logic [3:0] dst, logic [3:0] src, logic [2:0] op, int c);
    push(K_ALU, {7'b0, 1'b1, 1'b0, dst, dst, src, op}, c);
  endtask
  task automatic push_memld(logic [3:0] dst, logic [2:0] addr, int c);
    push(K_MEMLD, {13'b0, 1'b1, 1'b1, 1'b1, dst, addr, 1'b0}, c);
  endtask
  task automatic push_store(logic [3:0] dst, logic [2:0] addr, int c);
    push(K_STORE, {11'b0, 1'b1, 1'b1, 1'b0, dst, 3'd0, addr}, c);
  endtask
  task automatic push_pcl(logic [2:0] addr, int c);
    push(K_PCL, {19'b0, 1'b1, 1'b0, addr}, c);
  endtask
  task automatic push_halt(logic f, int c);
    push(K_HALT, {20'b0, 1'b1, f, 1'b0, 1'b0}, c);
  endtask

  // memory responder: acks each request after ack_delay wait cycles, feeding bytes from mem_q
  initial begin
    int w;
    w = 0;
    i_mem_ack = 1'b0;
    i_dat = 8'h00;
    forever begin
      @(negedge clk);
      if ((o_mem_rd || o_mem_wr) && !stall && w >= ack_delay) begin
        i_mem_ack = 1'b1;
        if (o_mem_rd) begin
          if (mem_q.size() > 0) i_dat = mem_q.pop_front();
          else                  i_dat = 8'h00;
        end
        w = 0;
      end else begin
        i_mem_ack = 1'b0;
        w = (o_mem_rd || o_mem_wr) ? w + 1 : 0;
      end
    end
  end

  // monitor: any strobe event or halt rise pops one expectation
  initial begin
    logic        halt_prev;
    logic        ev;
    logic [23:0] got;
    exp_t        e;
    halt_prev = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        ev = o_load || o_pc_load || (o_mem_wr && i_mem_ack) || (o_halt && !halt_prev);
        if (ev) begin
          n_vec++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got load=%b pc_load=%b wr=%b halt=%b required no event (cycle %0d)",
                     o_load, o_pc_load, o_mem_wr, o_halt, cyc);
          end else begin
            e = sb.pop_front();
            got = observe(e.kind);
            if (got !== e.sig) begin
              n_bad++;
              $display("FAIL %s_fields: got=%06h required=%06h (cycle %0d)", e.kind.name(), got, e.sig, cyc);
            end
            if (e.cyc >= 0) begin
              n_vec++;
              if (cyc != e.cyc) begin
                n_bad++;
                $display("FAIL %s_cycle: got=%0d required=%0d", e.kind.name(), cyc, e.cyc);
              end
            end
          end
        end
      end
      halt_prev = rst_n ? o_halt : 1'b0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    stall = 1'b0;
    ack_delay = 0;
    mem_q.delete();
    sb.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #3;
    chk("reset_outputs_zero",
        {o_mem_rd, o_mem_wr, o_dat_sel, o_load, o_load_reg_sel, o_alu_l_sel, o_alu_r_sel,
         o_addr_sel, o_op, o_pc_inc, o_pc_load, o_halt, o_fault}, 0);
  endtask

  task automatic wait_halt(int budget);
    int n;
    n = 0;
    while (!o_halt && n < budget) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("halt_reached", o_halt, 1);
    repeat (3) @(negedge clk);
    #3;
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    int rd_cnt;
    int n;
    rst_n = 1'b0;
    i_flags = 3'b000;

    // reset release, ALU 0x00 0x21, then HALT
    do_reset();
    mem_q = '{8'h00, 8'h21, 8'hC7, 8'h00};
    push_alu(4'd2, 4'd1, 3'd0, 4);
    push_halt(1'b0, 9);
    rst_n = 1'b1;
    @(negedge clk);
    #3;
    chk("release_fetch", {o_mem_rd, o_addr_sel, o_dat_sel}, {1'b1, 3'd7, 1'b1});
    wait_halt(100);
    rd_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      #3;
      if (o_mem_rd || o_mem_wr) rd_cnt++;
    end
    chk("halt_no_fetch", rd_cnt, 0);

    // LOAD r5 <= mem[pair 3] with 3 wait cycles on every transfer
    do_reset();
    mem_q = '{8'h40, 8'h53, 8'h5A, 8'hC7, 8'h00};
    ack_delay = 3;
    push_memld(4'd5, 3'd3, 13);
    push_halt(1'b0, 24);
    rst_n = 1'b1;
    wait_halt(200);

    // STORE r4 -> mem[pair 6]; op field 3 must be replaced by pass-through
    do_reset();
    mem_q = '{8'h98, 8'h46, 8'hC7, 8'h00};
    push_store(4'd4, 3'd6, 4);
    push_halt(1'b0, 9);
    rst_n = 1'b1;
    wait_halt(100);

    // JUMP if Z taken
    do_reset();
    i_flags = 3'b001;
    mem_q = '{8'hC1, 8'h05, 8'hC7, 8'h00};
    push_pcl(3'd5, 4);
    push_halt(1'b0, 9);
    rst_n = 1'b1;
    wait_halt(100);

    // Z clear: JUMP if Z not taken, JUMP if !Z taken
    do_reset();
    i_flags = 3'b000;
    mem_q = '{8'hC1, 8'h05, 8'hC2, 8'h03, 8'hC7, 8'h00};
    push_pcl(3'd3, 8);
    push_halt(1'b0, 13);
    rst_n = 1'b1;
    wait_halt(100);

    // N and C set: C taken, !C not, N taken, always taken
    do_reset();
    i_flags = 3'b110;
    mem_q = '{8'hC3, 8'h01, 8'hC4, 8'h02, 8'hC5, 8'h04, 8'hC0, 8'h07, 8'hC7, 8'h00};
    push_pcl(3'd1, 4);
    push_pcl(3'd4, 12);
    push_pcl(3'd7, 16);
    push_halt(1'b0, 21);
    rst_n = 1'b1;
    wait_halt(100);
    i_flags = 3'b000;

    // timeout: FETCH0 never acked
    do_reset();
    stall = 1'b1;
    push_halt(1'b1, 16);
    rst_n = 1'b1;
    rd_cnt = 0;
    n = 0;
    while (!o_halt && n < 100) begin
      @(negedge clk);
      #3;
      if (o_mem_rd) rd_cnt++;
      n++;
    end
    chk("timeout_rd_cycles", rd_cnt, 15);
    wait_halt(10);
    chk("timeout_fault_sticky", {o_fault, o_mem_rd}, {1'b1, 1'b0});

    // ack on the last allowed cycle wins over the timeout
    do_reset();
    ack_delay = 14;
    mem_q = '{8'h00, 8'h21, 8'hC7, 8'h00};
    push_alu(4'd2, 4'd1, 3'd0, -1);
    push_halt(1'b0, -1);
    rst_n = 1'b1;
    wait_halt(400);

    // reset during a pending fetch drops the request at the reset edge
    do_reset();
    stall = 1'b1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #3;
    chk("pending_before_reset", o_mem_rd, 1);
    rst_n = 1'b0;
    @(negedge clk);
    #3;
    chk("reset_drops_rd", {o_mem_rd, o_mem_wr, o_halt, o_fault}, 0);
    stall = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog expired");
  end

endmodule
